// File: rtl/ysyx_22040931_bpu.sv
// IF-stage branch predictor: direct-mapped BTB with 2-bit saturating counters,
// combinational lookup on the fetch PC, trained by ID-stage branch resolution.
module ysyx_22040931_bpu #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 10,
    parameter int PC_W  = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [PC_W-1:0] if_pc,
    output logic            pre_jump,
    output logic [PC_W-1:0] pre_branch,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [1:0]      upd_jumptype,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_error,
    output logic [31:0]     pred_total,
    output logic [31:0]     pred_correct
);

    localparam int unsigned N = 1 << IDX_W;

    typedef enum logic [1:0] {
        JT_NONE = 2'b00,
        JT_B    = 2'b01,
        JT_JAL  = 2'b10,
        JT_JALR = 2'b11
    } jt_e;

    logic [N-1:0]      r_valid;
    logic [TAG_W-1:0]  r_tag    [N];
    logic [PC_W-1:0]   r_target [N];
    logic [1:0]        r_type   [N];
    logic [1:0]        r_ctr    [N];
    logic [31:0]       r_total;
    logic [31:0]       r_correct;

    logic [IDX_W-1:0]  w_if_idx;
    logic [TAG_W-1:0]  w_if_tag;
    logic              w_if_hit;
    logic [IDX_W-1:0]  w_upd_idx;
    logic [TAG_W-1:0]  w_upd_tag;
    logic              w_upd_hit;
    logic              w_upd_cf;
    logic [1:0]        w_ctr_inc;
    logic [1:0]        w_ctr_dec;

    assign w_if_idx  = if_pc[IDX_W+1:2];
    assign w_if_tag  = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_upd_idx = upd_pc[IDX_W+1:2];
    assign w_upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_upd_cf  = (upd_jumptype != JT_NONE);

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    always_comb begin
        w_if_hit   = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
        pre_jump   = w_if_hit && ((r_type[w_if_idx] != JT_B) || r_ctr[w_if_idx][1]);
        pre_branch = pre_jump ? r_target[w_if_idx] : '0;
    end

    always_comb begin
        w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
        w_ctr_inc = (r_ctr[w_upd_idx] == 2'b11) ? 2'b11 : r_ctr[w_upd_idx] + 2'b01;
        w_ctr_dec = (r_ctr[w_upd_idx] == 2'b00) ? 2'b00 : r_ctr[w_upd_idx] - 2'b01;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid   <= '0;
            r_total   <= '0;
            r_correct <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_type[i]   <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (upd_valid) begin
            if (w_upd_cf) begin
                r_total <= r_total + 32'd1;
                if (!upd_error)
                    r_correct <= r_correct + 32'd1;
                if (w_upd_hit) begin
                    if (upd_jumptype == JT_B)
                        r_ctr[w_upd_idx] <= upd_taken ? w_ctr_inc : w_ctr_dec;
                    else
                        r_ctr[w_upd_idx] <= 2'b11;
                    if (upd_taken)
                        r_target[w_upd_idx] <= upd_target;
                    r_type[w_upd_idx] <= upd_jumptype;
                end else if (upd_taken) begin
                    // Allocation overwrites whatever alias occupies the slot.
                    r_valid[w_upd_idx]  <= 1'b1;
                    r_tag[w_upd_idx]    <= w_upd_tag;
                    r_target[w_upd_idx] <= upd_target;
                    r_type[w_upd_idx]   <= upd_jumptype;
                    r_ctr[w_upd_idx]    <= (upd_jumptype == JT_B) ? 2'b10 : 2'b11;
                end
            end else if (w_upd_hit && upd_error) begin
                // A non-branch that was predicted taken means the entry is a stale alias.
                r_valid[w_upd_idx] <= 1'b0;
            end
        end
    end

    assign pred_total   = r_total;
    assign pred_correct = r_correct;

endmodule

// File: tb/tb_ysyx_22040931_bpu.sv
// Directed bench for the BTB predictor: training, saturation, aliasing,
// invalidation, same-cycle update/lookup and asynchronous reset.
module tb_ysyx_22040931_bpu;

    logic        clock;
    logic        reset;
    logic [63:0] if_pc;
    logic        pre_jump;
    logic [63:0] pre_branch;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic [1:0]  upd_jumptype;
    logic        upd_taken;
    logic [63:0] upd_target;
    logic        upd_error;
    logic [31:0] pred_total;
    logic [31:0] pred_correct;

    int n_checks;
    int n_fail;
    int exp_total;
    int exp_correct;

    ysyx_22040931_bpu #(.IDX_W(4), .TAG_W(10), .PC_W(64)) dut (
        .clock        (clock),
        .reset        (reset),
        .if_pc        (if_pc),
        .pre_jump     (pre_jump),
        .pre_branch   (pre_branch),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_jumptype (upd_jumptype),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .upd_error    (upd_error),
        .pred_total   (pred_total),
        .pred_correct (pred_correct)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic upd(input logic [63:0] pc, input logic [1:0] jt, input logic tk,
                       input logic [63:0] tgt, input logic err);
        upd_pc       = pc;
        upd_jumptype = jt;
        upd_taken    = tk;
        upd_target   = tgt;
        upd_error    = err;
        upd_valid    = 1'b1;
        tick();
        upd_valid = 1'b0;
        if (jt != 2'b00) begin
            exp_total++;
            if (!err) exp_correct++;
        end
    endtask

    task automatic pred(input string tag, input logic [63:0] pc, input logic pj, input logic [63:0] pb);
        if_pc = pc;
        #1;
        check({tag, "_jump"}, {63'd0, pre_jump}, {63'd0, pj});
        check({tag, "_target"}, pre_branch, pb);
    endtask

    task automatic counters(input string tag);
        check({tag, "_total"}, {32'd0, pred_total}, 64'(exp_total));
        check({tag, "_correct"}, {32'd0, pred_correct}, 64'(exp_correct));
    endtask

    initial begin
        n_checks = 0; n_fail = 0; exp_total = 0; exp_correct = 0;
        reset = 1'b0;
        if_pc = 64'h8000_0000;
        upd_valid = 1'b0; upd_pc = '0; upd_jumptype = 2'b00;
        upd_taken = 1'b0; upd_target = '0; upd_error = 1'b0;
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        tick();

        // Post-reset state
        pred("reset", 64'h8000_0000, 1'b0, 64'h0);
        counters("reset");

        // First B allocation, ctr=10
        upd(64'h8000_0010, 2'b01, 1'b1, 64'h8000_0040, 1'b1);
        pred("alloc_b", 64'h8000_0010, 1'b1, 64'h8000_0040);
        counters("alloc_b");

        // Down to 00 and stay there
        upd(64'h8000_0010, 2'b01, 1'b0, 64'h0, 1'b0);
        pred("nt1_ctr01", 64'h8000_0010, 1'b0, 64'h0);
        upd(64'h8000_0010, 2'b01, 1'b0, 64'h0, 1'b0);
        pred("nt2_ctr00", 64'h8000_0010, 1'b0, 64'h0);
        upd(64'h8000_0010, 2'b01, 1'b0, 64'h0, 1'b1);
        upd(64'h8000_0010, 2'b01, 1'b1, 64'h8000_0040, 1'b1);
        pred("sat_low_ctr01", 64'h8000_0010, 1'b0, 64'h0);

        // Up to 11 and stay there
        upd(64'h8000_0010, 2'b01, 1'b1, 64'h8000_0040, 1'b0);
        pred("t_ctr10", 64'h8000_0010, 1'b1, 64'h8000_0040);
        upd(64'h8000_0010, 2'b01, 1'b1, 64'h8000_0040, 1'b0);
        upd(64'h8000_0010, 2'b01, 1'b1, 64'h8000_0040, 1'b0);
        upd(64'h8000_0010, 2'b01, 1'b1, 64'h8000_0040, 1'b0);
        upd(64'h8000_0010, 2'b01, 1'b0, 64'h0, 1'b1);
        pred("sat_high_ctr10", 64'h8000_0010, 1'b1, 64'h8000_0040);
        upd(64'h8000_0010, 2'b01, 1'b0, 64'h0, 1'b1);
        pred("dec_ctr01", 64'h8000_0010, 1'b0, 64'h0);
        upd(64'h8000_0010, 2'b01, 1'b1, 64'h8000_0044, 1'b1);
        pred("retarget_ctr10", 64'h8000_0010, 1'b1, 64'h8000_0044);
        counters("after_training");

        // Aliasing on idx 4
        pred("alias_miss", 64'h8000_0050, 1'b0, 64'h0);
        upd(64'h8000_0050, 2'b10, 1'b1, 64'h8000_0100, 1'b1);
        pred("alias_jal", 64'h8000_0050, 1'b1, 64'h8000_0100);
        pred("alias_evicted", 64'h8000_0010, 1'b0, 64'h0);
        upd(64'h8000_0090, 2'b01, 1'b0, 64'h0, 1'b0);
        pred("miss_nt_nochange", 64'h8000_0050, 1'b1, 64'h8000_0100);
        counters("alias");

        // Invalidation rules
        upd(64'h8000_0020, 2'b11, 1'b1, 64'h8000_0200, 1'b0);
        upd(64'h8000_0020, 2'b00, 1'b0, 64'h0, 1'b0);
        pred("none_noerr_keeps", 64'h8000_0020, 1'b1, 64'h8000_0200);
        upd_pc = 64'h8000_0020; upd_jumptype = 2'b00; upd_error = 1'b1; upd_valid = 1'b0;
        tick();
        pred("upd_valid0_keeps", 64'h8000_0020, 1'b1, 64'h8000_0200);
        upd(64'h8000_0050, 2'b00, 1'b0, 64'h0, 1'b1);
        pred("invalidated", 64'h8000_0050, 1'b0, 64'h0);
        counters("invalidate");

        // Same-cycle update and lookup: old value then new
        if_pc = 64'h8000_0020;
        upd_pc = 64'h8000_0020; upd_jumptype = 2'b11; upd_taken = 1'b1;
        upd_target = 64'h8000_0300; upd_error = 1'b1; upd_valid = 1'b1;
        #1;
        check("same_cycle_old", pre_branch, 64'h8000_0200);
        tick();
        upd_valid = 1'b0;
        exp_total++;
        pred("same_cycle_new", 64'h8000_0020, 1'b1, 64'h8000_0300);
        counters("pre_reset");

        // Asynchronous reset mid-cycle with an update in flight
        upd_pc = 64'h8000_0030; upd_jumptype = 2'b10; upd_taken = 1'b1;
        upd_target = 64'h8000_0400; upd_error = 1'b0; upd_valid = 1'b1;
        #1 reset = 1'b0;
        exp_total = 0; exp_correct = 0;
        #1;
        check("async_rst_jump", {63'd0, pre_jump}, 64'd0);
        check("async_rst_target", pre_branch, 64'h0);
        counters("async_rst");
        tick();
        #2 reset = 1'b1;
        upd_valid = 1'b0;
        tick();
        pred("dropped_update", 64'h8000_0030, 1'b0, 64'h0);
        pred("cleared_entry", 64'h8000_0020, 1'b0, 64'h0);
        counters("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
